oram_arbiter: RTL and testbench
===============================

Name: oram_arbiter

Overview:
- Two-requester Avalon-MM arbiter and transaction sequencer in front of the single ORAM driver port.
- Serialises requests from port 0 and port 1 with round-robin priority.
- For each access: issues a one-cycle read/write strobe to the ORAM, waits for its variable-latency completion, and returns read data through a waitrequest handshake.
- A watchdog terminates any access the ORAM never completes.

Parameters:
- ADDRESS_WIDTH, 4, word address width, shared by both requesters and the ORAM port.
- BYTE_WIDTH, 8, bits per byte.
- BYTES_PER_WORD, 4, bytes per data word. Data width DW = BYTE_WIDTH*BYTES_PER_WORD.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before forced completion. Must be at least 2.

Ports:
- clock, in, 1: single clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- avs_p0_address / avs_p1_address, in, ADDRESS_WIDTH: requester word address.
- avs_p0_read / avs_p1_read, in, 1: read request; held until waitrequest is low.
- avs_p0_write / avs_p1_write, in, 1: write request; held until waitrequest is low.
- avs_p0_byteenable / avs_p1_byteenable, in, BYTES_PER_WORD: byte enables.
- avs_p0_writedata / avs_p1_writedata, in, DW: write data.
- avs_p0_readdata / avs_p1_readdata, out, DW: read data, valid in the cycle waitrequest is low.
- avs_p0_waitrequest / avs_p1_waitrequest, out, 1: low for exactly one cycle when the transfer completes.
- oram_address, out, ADDRESS_WIDTH: latched address to the ORAM driver.
- oram_byteenable, out, BYTES_PER_WORD: latched byte enables.
- oram_writedata, out, DW: latched write data.
- oram_read, out, 1: one-cycle read strobe.
- oram_write, out, 1: one-cycle write strobe.
- oram_readdata, in, DW: ORAM result.
- oram_done, in, 1: ORAM completion (output_ready) pulse.
- busy, out, 1: high in every state except IDLE.
- timeout_err, out, 1: sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all counters cleared, last_grant=1 (so port 0 wins the first tie).
  - oram_read=0, oram_write=0; oram_address, oram_byteenable, oram_writedata = 0.
  - Both readdata = 0, both waitrequest = 1, busy=0, timeout_err=0.
  - Reset mid-transaction drops the transaction silently. No completion is ever returned for it.
- A port requests when its read|write is high. If read and write are both high, the access is a write.
- IDLE:
  - If exactly one port requests, grant it.
  - If both request, grant the port != last_grant.
  - On grant, latch address, byteenable, writedata and rw into the oram_* registers, then go to ISSUE.
  - oram_done is ignored in IDLE.
- ISSUE (1 cycle):
  - oram_write=rw and oram_read=~rw for this cycle only.
  - Clear the watchdog counter, then go to WAIT.
  - oram_done is ignored in ISSUE.
- WAIT:
  - The counter increments each cycle.
  - If oram_done=1: latch oram_readdata into the granted port's readdata register (writes latch it too; the value is don't-care), then go to RESP.
  - Else, if counter == TIMEOUT_CYCLES-1: set timeout_err=1, load granted readdata = 0, then go to RESP.
  - If oram_done arrives in the same cycle as the timeout, done wins and timeout_err is not set.
- RESP (1 cycle):
  - Granted port's waitrequest = 0; the other port stays 1.
  - last_grant = granted port, then go to IDLE.
- waitrequest is 1 in every cycle except the granted port's RESP cycle.
- readdata registers hold their value until the next completion on that port.
- oram_* address/data outputs hold their latched value until the next grant.
- Requester inputs changing after grant have no effect; the latched copies are used.
- Latency: request seen in IDLE at cycle t, strobe at t+1. If oram_done is first seen at t+1+k (k≥1), waitrequest goes low at t+2+k. Minimum request-to-completion is 3 cycles.
- The earliest new grant is in the IDLE cycle after RESP, so the minimum back-to-back period is 4 cycles per transaction.
- timeout_err clears only on reset.

Test Plan:
- Port 0 reads address 0x3; ORAM pulses oram_done with 0x11223344 four cycles after the strobe:
  - oram_read high for exactly 1 cycle with oram_address=0x3 and oram_write=0.
  - avs_p0_waitrequest low for exactly 1 cycle, 5 cycles after the strobe, with avs_p0_readdata=0x11223344.
  - avs_p1_waitrequest stays 1 throughout.
- Both ports request continuously from reset release, each ORAM access completing after 2 cycles:
  - Grant order is 0,1,0,1; each port sees one waitrequest-low cycle per 2 transactions.
- Port 1 writes address 0xA, data 0xCAFEF00D, byteenable 4'b0101:
  - oram_write pulses 1 cycle with those exact values; oram_read stays 0.
  - avs_p1_waitrequest low 1 cycle after oram_done.
- TIMEOUT_CYCLES=16, ORAM never asserts done on a port 0 read:
  - avs_p0_waitrequest goes low exactly 16 WAIT cycles after the strobe, with readdata=0.
  - timeout_err=1 and stays 1 through later successful accesses until reset.
- Reset asserted during WAIT:
  - Same cycle (asynchronous): waitrequest=1, oram strobes=0, busy=0.
  - After release, a stale oram_done is ignored in IDLE.
  - Next port 1 request completes normally.
- Port 0 asserts read and write together at address 0x5:
  - Treated as a write: oram_write pulses, oram_read stays 0.

Source files
------------

// File: rtl/oram_arbiter.sv
// oram_arbiter: round-robin two-port Avalon-MM front end for the ORAM driver.
// One access in flight at a time; a watchdog forces completion if oram_done never comes.
module oram_arbiter #(
    parameter int ADDRESS_WIDTH  = 4,
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH-1:0]             avs_p0_address,
    input  logic                                 avs_p0_read,
    input  logic                                 avs_p0_write,
    input  logic [BYTES_PER_WORD-1:0]            avs_p0_byteenable,
    input  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] avs_p0_writedata,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] avs_p0_readdata,
    output logic                                 avs_p0_waitrequest,
    input  logic [ADDRESS_WIDTH-1:0]             avs_p1_address,
    input  logic                                 avs_p1_read,
    input  logic                                 avs_p1_write,
    input  logic [BYTES_PER_WORD-1:0]            avs_p1_byteenable,
    input  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] avs_p1_writedata,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] avs_p1_readdata,
    output logic                                 avs_p1_waitrequest,
    output logic [ADDRESS_WIDTH-1:0]             oram_address,
    output logic [BYTES_PER_WORD-1:0]            oram_byteenable,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] oram_writedata,
    output logic                                 oram_read,
    output logic                                 oram_write,
    input  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] oram_readdata,
    input  logic                                 oram_done,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic          grant;
    logic          last_grant;
    logic          rw;
    logic [CW-1:0] cnt;

    logic req0;
    logic req1;
    logic pick;
    logic pick_wr;

    always_comb begin
        req0    = avs_p0_read | avs_p0_write;
        req1    = avs_p1_read | avs_p1_write;
        pick    = (req0 & req1) ? ~last_grant : req1;
        pick_wr = pick ? avs_p1_write : avs_p0_write;
    end

    assign oram_read          = (state == ISSUE) & ~rw;
    assign oram_write         = (state == ISSUE) & rw;
    assign busy               = (state != IDLE);
    assign avs_p0_waitrequest = ~((state == RESP) & ~grant);
    assign avs_p1_waitrequest = ~((state == RESP) & grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            grant           <= 1'b0;
            last_grant      <= 1'b1;
            rw              <= 1'b0;
            cnt             <= '0;
            oram_address    <= '0;
            oram_byteenable <= '0;
            oram_writedata  <= '0;
            avs_p0_readdata <= '0;
            avs_p1_readdata <= '0;
            timeout_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant           <= pick;
                        rw              <= pick_wr;
                        oram_address    <= pick ? avs_p1_address : avs_p0_address;
                        oram_byteenable <= pick ? avs_p1_byteenable : avs_p0_byteenable;
                        oram_writedata  <= pick ? avs_p1_writedata : avs_p0_writedata;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the final watchdog cycle still counts as success.
                    if (oram_done) begin
                        if (grant) avs_p1_readdata <= oram_readdata;
                        else       avs_p0_readdata <= oram_readdata;
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        if (grant) avs_p1_readdata <= '0;
                        else       avs_p0_readdata <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oram_arbiter.sv
// tb_oram_arbiter: random two-port traffic against a transaction-level model.
// The bench also plays the ORAM, with its own memory fed from the DUT's oram_* outputs.
module tb_oram_arbiter;

    localparam int AW   = 4;
    localparam int BPW  = 4;
    localparam int DW   = 32;
    localparam int T    = 16;
    localparam int NCYC = 4000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic          req_rd   [2];
    logic          req_wr   [2];
    logic [AW-1:0] req_addr [2];
    logic [BPW-1:0] req_be  [2];
    logic [DW-1:0] req_wd   [2];

    logic [DW-1:0]  rdata0, rdata1;
    logic           wreq0, wreq1;
    logic [AW-1:0]  oram_address;
    logic [BPW-1:0] oram_byteenable;
    logic [DW-1:0]  oram_writedata;
    logic           oram_read, oram_write;
    logic [DW-1:0]  oram_readdata;
    logic           oram_done;
    logic           busy, timeout_err;

    oram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock),
        .reset(reset),
        .avs_p0_address(req_addr[0]),
        .avs_p0_read(req_rd[0]),
        .avs_p0_write(req_wr[0]),
        .avs_p0_byteenable(req_be[0]),
        .avs_p0_writedata(req_wd[0]),
        .avs_p0_readdata(rdata0),
        .avs_p0_waitrequest(wreq0),
        .avs_p1_address(req_addr[1]),
        .avs_p1_read(req_rd[1]),
        .avs_p1_write(req_wr[1]),
        .avs_p1_byteenable(req_be[1]),
        .avs_p1_writedata(req_wd[1]),
        .avs_p1_readdata(rdata1),
        .avs_p1_waitrequest(wreq1),
        .oram_address(oram_address),
        .oram_byteenable(oram_byteenable),
        .oram_writedata(oram_writedata),
        .oram_read(oram_read),
        .oram_write(oram_write),
        .oram_readdata(oram_readdata),
        .oram_done(oram_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [BPW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BPW; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // transaction model state
    bit             act, to, last, terr, did_rst, p1_first;
    int             gp, s_cyc, d_cyc, r_cyc, k;
    bit             m_rw;
    logic [AW-1:0]  m_addr;
    logic [BPW-1:0] m_be;
    logic [DW-1:0]  m_wd;
    logic [AW-1:0]  e_addr;
    logic [BPW-1:0] e_be;
    logic [DW-1:0]  e_wd;
    logic [DW-1:0]  e_rd [2];
    bit             e_ok [2];
    logic [DW-1:0]  nxt_rd;
    bit             nxt_ok;
    bit             pend [2];
    bit             fin  [2];
    logic [DW-1:0]  ref_mem  [16];
    logic [DW-1:0]  oram_mem [16];
    // what the DUT actually presented at the strobe
    logic [AW-1:0]  o_addr;
    logic [BPW-1:0] o_be;
    logic [DW-1:0]  o_wd;
    logic           o_wr;

    task automatic model_reset();
        act = 0; last = 1; terr = 0;
        e_addr = '0; e_be = '0; e_wd = '0;
        for (int p = 0; p < 2; p++) begin
            e_rd[p] = '0; e_ok[p] = 1; pend[p] = 0; fin[p] = 0;
            req_rd[p] = 0; req_wr[p] = 0;
            req_addr[p] = '0; req_be[p] = '0; req_wd[p] = '0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr0"}, wreq0, 1'b1);
        check({tag, "_wr1"}, wreq1, 1'b1);
        check({tag, "_rd"}, oram_read, 1'b0);
        check({tag, "_wrs"}, oram_write, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_terr"}, timeout_err, 1'b0);
        check({tag, "_rdata0"}, rdata0, '0);
        check({tag, "_rdata1"}, rdata1, '0);
        check({tag, "_addr"}, oram_address, '0);
    endtask

    initial begin
        logic [DW-1:0] v;
        int ty;
        bit in_wait;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            oram_mem[i] = v;
        end
        model_reset();
        did_rst = 0; p1_first = 0;
        oram_done = 0; oram_readdata = '0;
        n = -1;
        repeat (2) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        check("reset_be", oram_byteenable, '0);
        check("reset_wd", oram_writedata, '0);
        reset = 1;

        while (n < NCYC) begin
            @(posedge clock);
            #1;
            n++;

            if (!did_rst && act && n > 2000 && n > s_cyc && n < r_cyc) begin
                did_rst = 1;
                reset = 0;
                #1;
                check_idle_outputs("arst");
                model_reset();
                oram_done = 0;
                @(posedge clock);
                #1;
                n++;
                check_idle_outputs("inrst");
                oram_done = 1;
                oram_readdata = $urandom;
                reset = 1;
                p1_first = 1;
                continue;
            end

            // effects that became visible at this edge
            if (act && n == s_cyc) begin
                e_addr = m_addr; e_be = m_be; e_wd = m_wd;
            end
            if (act && n == r_cyc) begin
                e_rd[gp] = nxt_rd; e_ok[gp] = nxt_ok;
                if (to) terr = 1;
            end

            check("oram_read", oram_read, act && n == s_cyc && !m_rw);
            check("oram_write", oram_write, act && n == s_cyc && m_rw);
            check("busy", busy, act && n >= s_cyc && n <= r_cyc);
            check("wreq0", wreq0, !(act && n == r_cyc && gp == 0));
            check("wreq1", wreq1, !(act && n == r_cyc && gp == 1));
            check("timeout_err", timeout_err, terr);
            check("oram_address", oram_address, e_addr);
            check("oram_be", oram_byteenable, e_be);
            check("oram_wd", oram_writedata, e_wd);
            if (e_ok[0]) check("rdata0", rdata0, e_rd[0]);
            if (e_ok[1]) check("rdata1", rdata1, e_rd[1]);

            if (act && n == s_cyc) begin
                o_addr = oram_address; o_be = oram_byteenable;
                o_wd = oram_writedata; o_wr = oram_write;
            end

            // requesters
            for (int p = 0; p < 2; p++) begin
                if (fin[p]) begin
                    fin[p] = 0; pend[p] = 0;
                    req_rd[p] = 0; req_wr[p] = 0;
                end
                if (!pend[p] && !(p == 0 && p1_first) && $urandom_range(0, 3) == 0) begin
                    ty = $urandom_range(0, 7);
                    pend[p] = 1;
                    req_rd[p] = (ty < 4) || (ty == 7);
                    req_wr[p] = (ty >= 4);
                    req_addr[p] = AW'($urandom);
                    req_be[p] = BPW'($urandom);
                    req_wd[p] = $urandom;
                end
            end
            // the granted port's latched copies must be what counts
            if (act && n >= s_cyc) begin
                req_addr[gp] = AW'($urandom);
                req_be[gp] = BPW'($urandom);
                req_wd[gp] = $urandom;
            end

            // ORAM side
            in_wait = act && n > s_cyc && n < r_cyc;
            oram_done = 0;
            if (act && !to && n == d_cyc) begin
                oram_done = 1;
                if (o_wr) begin
                    oram_mem[o_addr] = merge(oram_mem[o_addr], o_wd, o_be);
                    oram_readdata = $urandom;
                end else begin
                    oram_readdata = oram_mem[o_addr];
                end
                if (m_rw) begin
                    ref_mem[m_addr] = merge(ref_mem[m_addr], m_wd, m_be);
                    nxt_ok = 0;
                end else begin
                    nxt_rd = ref_mem[m_addr];
                    nxt_ok = 1;
                end
            end else if (!in_wait && $urandom_range(0, 5) == 0) begin
                oram_done = 1;
                oram_readdata = $urandom;
            end

            // arbitration
            if (!act && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) gp = last ? 0 : 1;
                else gp = pend[1] ? 1 : 0;
                if (p1_first) check("post_rst_port", gp, 1);
                p1_first = 0;
                act = 1;
                s_cyc = n + 1;
                m_rw = req_wr[gp];
                m_addr = req_addr[gp];
                m_be = req_be[gp];
                m_wd = req_wd[gp];
                to = ($urandom_range(0, 9) == 0);
                case ($urandom_range(0, 7))
                    0: k = T;
                    1: k = T - 1;
                    default: k = $urandom_range(1, 4);
                endcase
                d_cyc = s_cyc + k;
                r_cyc = to ? s_cyc + 1 + T : s_cyc + 1 + k;
                if (to) begin
                    nxt_rd = '0;
                    nxt_ok = 1;
                end
            end else if (act && n == r_cyc) begin
                last = (gp == 1);
                act = 0;
                fin[gp] = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
